minaret_mem_arbiter: RTL and testbench

Shares one single-ported memory between the minaret core's instruction port (imem) and data port (dmem), both using the valid/ready interface. Decodes the console MMIO address and forwards byte writes to a console sink instead of memory. Sits between the minaret core and the unified RAM. Replaces the dual-read-port memory model with a realistic single-port system.

---
 rtl/minaret_bus_pkg.sv | 18 +
 rtl/minaret_rr_arb2.sv | 37 +++
 rtl/minaret_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_minaret_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/minaret_bus_pkg.sv
// Shared types and constants for the minaret single-port memory arbiter.
package minaret_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_CON  = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_IMEM = 1'b0,
    REQ_DMEM = 1'b1
  } req_id_e;

  localparam logic [31:0] CON_ADDR_DEFAULT = 32'hffff_ff04;

endpackage

// File: rtl/minaret_rr_arb2.sv
// Two-input round-robin arbiter: on a contest the requester not granted last time wins.
module minaret_rr_arb2
  import minaret_bus_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_imem_i,
  input  logic req_dmem_i,
  input  logic update_i,
  output logic gnt_valid_o,
  output logic gnt_dmem_o
);

  req_id_e last_q, last_d;

  always_comb begin
    gnt_valid_o = req_imem_i | req_dmem_i;
    if (req_imem_i && req_dmem_i) begin
      gnt_dmem_o = (last_q == REQ_IMEM);
    end else begin
      gnt_dmem_o = req_dmem_i;
    end
    last_d = last_q;
    if (update_i && gnt_valid_o) begin
      last_d = gnt_dmem_o ? REQ_DMEM : REQ_IMEM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= REQ_IMEM;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/minaret_mem_arbiter.sv
// Shares one single-ported RAM between the imem and dmem ports and diverts
// dmem writes at the console address to a byte-wide console sink.
module minaret_mem_arbiter
  import minaret_bus_pkg::*;
#(
  parameter logic [31:0] CON_ADDR       = CON_ADDR_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter int          TO_W           = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_valid,
  output logic        imem_ready,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  input  logic        dmem_valid,
  output logic        dmem_ready,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        con_valid,
  input  logic        con_ready,
  output logic [7:0]  con_data,
  output logic        bus_error
);

  localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_e      state_q, state_d;
  req_id_e         owner_q, owner_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      wmask_q, wmask_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            berr_q, berr_d;

  logic gnt_valid;
  logic gnt_dmem;
  logic is_con;
  logic to_hit;

  minaret_rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req_imem_i (imem_valid),
    .req_dmem_i (dmem_valid),
    .update_i   (state_q == ST_IDLE),
    .gnt_valid_o(gnt_valid),
    .gnt_dmem_o (gnt_dmem)
  );

  assign is_con = (dmem_addr == CON_ADDR);
  // Last waiting cycle: the counter would reach TIMEOUT_CYCLES on this edge.
  assign to_hit = TO_EN && (cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          if (!gnt_dmem) begin
            state_d = ST_MEM;
          end else if (is_con) begin
            state_d = (dmem_wmask != 4'h0) ? ST_CON : ST_RESP;
          end else begin
            state_d = ST_MEM;
          end
        end
      end
      ST_MEM:  if (mem_ready || to_hit) state_d = ST_RESP;
      ST_CON:  if (con_ready || to_hit) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding registers: payload frozen at grant, response data captured on completion.
  always_comb begin
    owner_d = owner_q;
    addr_d  = addr_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    berr_d  = berr_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_dmem ? REQ_DMEM : REQ_IMEM;
          addr_d  = gnt_dmem ? dmem_addr : imem_addr;
          wmask_d = gnt_dmem ? dmem_wmask : 4'h0;
          wdata_d = gnt_dmem ? dmem_wdata : 32'h0;
          rdata_d = 32'h0;
          cnt_d   = '0;
        end
      end
      ST_MEM: begin
        cnt_d = cnt_q + TO_W'(1);
        if (mem_ready) begin
          rdata_d = mem_rdata;
        end else if (to_hit) begin
          berr_d = 1'b1;
        end
      end
      ST_CON: begin
        cnt_d = cnt_q + TO_W'(1);
        if (!con_ready && to_hit) begin
          berr_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= REQ_IMEM;
      addr_q  <= 32'h0;
      wmask_q <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      cnt_q   <= '0;
      berr_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      berr_q  <= berr_d;
    end
  end

  always_comb begin
    mem_valid  = (state_q == ST_MEM);
    mem_addr   = mem_valid ? addr_q : 32'h0;
    mem_wmask  = mem_valid ? wmask_q : 4'h0;
    mem_wdata  = mem_valid ? wdata_q : 32'h0;
    con_valid  = (state_q == ST_CON);
    con_data   = con_valid ? wdata_q[7:0] : 8'h0;
    imem_ready = (state_q == ST_RESP) && (owner_q == REQ_IMEM);
    dmem_ready = (state_q == ST_RESP) && (owner_q == REQ_DMEM);
    imem_rdata = imem_ready ? rdata_q : 32'h0;
    dmem_rdata = dmem_ready ? rdata_q : 32'h0;
    bus_error  = berr_q;
  end

endmodule

// File: tb/tb_minaret_mem_arbiter.sv
// Directed-vector bench for minaret_mem_arbiter: one table row per clock cycle.
module tb_minaret_mem_arbiter;

  localparam logic [31:0] CON = 32'hffff_ff04;

  typedef struct packed {
    logic        rst;
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic [3:0]  dm;
    logic [31:0] dw;
    logic        mr;
    logic [31:0] mrd;
    logic        cr;
  } ins_t;

  typedef struct packed {
    logic        mv;
    logic [31:0] ma;
    logic [3:0]  mm;
    logic [31:0] mw;
    logic        ir;
    logic [31:0] ird;
    logic        dr;
    logic [31:0] drd;
    logic        cv;
    logic [7:0]  cd;
    logic        be;
  } outs_t;

  typedef struct {
    string name;
    ins_t  i;
    outs_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_valid = 1'b0, imem_ready;
  logic [31:0] imem_addr = '0, imem_rdata;
  logic        dmem_valid = 1'b0, dmem_ready;
  logic [31:0] dmem_addr = '0, dmem_rdata;
  logic [3:0]  dmem_wmask = '0;
  logic [31:0] dmem_wdata = '0;
  logic        mem_valid, mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_wmask;
  logic        con_valid, con_ready = 1'b0;
  logic [7:0]  con_data;
  logic        bus_error;

  int nvec = 0;
  int nerr = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  minaret_mem_arbiter #(
    .CON_ADDR      (CON),
    .TIMEOUT_CYCLES(4),
    .TO_W          (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .imem_valid(imem_valid),
    .imem_ready(imem_ready),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .dmem_valid(dmem_valid),
    .dmem_ready(dmem_ready),
    .dmem_addr (dmem_addr),
    .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .con_valid (con_valid),
    .con_ready (con_ready),
    .con_data  (con_data),
    .bus_error (bus_error)
  );

  function automatic ins_t vi(input logic rst, input logic iv, input logic [31:0] ia,
                              input logic dv, input logic [31:0] da, input logic [3:0] dm,
                              input logic [31:0] dw, input logic mr, input logic [31:0] mrd,
                              input logic cr);
    ins_t r;
    r.rst = rst; r.iv = iv; r.ia = ia; r.dv = dv; r.da = da;
    r.dm = dm; r.dw = dw; r.mr = mr; r.mrd = mrd; r.cr = cr;
    return r;
  endfunction

  function automatic outs_t o_idle(input logic be);
    outs_t r;
    r = '0;
    r.be = be;
    return r;
  endfunction

  function automatic outs_t o_mem(input logic [31:0] a, input logic [3:0] m,
                                  input logic [31:0] w, input logic be);
    outs_t r;
    r = o_idle(be);
    r.mv = 1'b1; r.ma = a; r.mm = m; r.mw = w;
    return r;
  endfunction

  function automatic outs_t o_ir(input logic [31:0] d, input logic be);
    outs_t r;
    r = o_idle(be);
    r.ir = 1'b1; r.ird = d;
    return r;
  endfunction

  function automatic outs_t o_dr(input logic [31:0] d, input logic be);
    outs_t r;
    r = o_idle(be);
    r.dr = 1'b1; r.drd = d;
    return r;
  endfunction

  function automatic outs_t o_con(input logic [7:0] c, input logic be);
    outs_t r;
    r = o_idle(be);
    r.cv = 1'b1; r.cd = c;
    return r;
  endfunction

  function automatic outs_t sample();
    outs_t r;
    r.mv = mem_valid;  r.ma = mem_addr;    r.mm = mem_wmask; r.mw = mem_wdata;
    r.ir = imem_ready; r.ird = imem_rdata; r.dr = dmem_ready; r.drd = dmem_rdata;
    r.cv = con_valid;  r.cd = con_data;    r.be = bus_error;
    return r;
  endfunction

  task automatic add(input string n, input ins_t i, input outs_t o);
    vec_t v;
    v.name = n; v.i = i; v.o = o;
    tbl.push_back(v);
  endtask

  // Drive one cycle's inputs at the falling edge; outputs then show the current state.
  task automatic apply(input ins_t i);
    @(negedge clk);
    reset      = i.rst;
    imem_valid = i.iv;  imem_addr  = i.ia;
    dmem_valid = i.dv;  dmem_addr  = i.da;
    dmem_wmask = i.dm;  dmem_wdata = i.dw;
    mem_ready  = i.mr;  mem_rdata  = i.mrd;
    con_ready  = i.cr;
    #1;
  endtask

  task automatic check(input string n, input outs_t exp);
    outs_t got;
    got = sample();
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h expected=%h", n, got, exp);
    end
  endtask

  task automatic step(input string n, input ins_t i, input outs_t o);
    apply(i);
    check(n, o);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t z, w1, alt, cw, cr4, crd, rd0, rd1, rd3;
    int   mv_cnt;
    bit   seen;

    z   = vi(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    w1  = vi(0, 0, 0, 1, 32'h100, 4'hF, 32'hDEADBEEF, 1, 0, 0);
    alt = vi(0, 1, 32'h40, 1, 32'h80, 4'h0, 0, 1, 32'h1234_5678, 0);
    cw  = vi(0, 0, 0, 1, CON, 4'h1, 32'hCAFE_0041, 1, 32'h1234_5678, 0);
    cr4 = vi(0, 0, 0, 1, CON, 4'h1, 32'hCAFE_0041, 1, 32'h1234_5678, 1);
    crd = vi(0, 0, 0, 1, CON, 4'h0, 0, 1, 32'h1234_5678, 0);
    rd0 = vi(0, 1, 32'h200, 0, 0, 4'h0, 0, 0, 32'hFFFF_FFFF, 0);
    rd1 = vi(0, 1, 32'h999, 0, 0, 4'h0, 0, 0, 32'hFFFF_FFFF, 0);
    rd3 = vi(0, 1, 32'h999, 0, 0, 4'h0, 0, 1, 32'h0000_0013, 0);

    add("reset", vi(1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0), o_idle(0));
    add("wr_c0", w1, o_idle(0));
    add("wr_c1", w1, o_mem(32'h100, 4'hF, 32'hDEADBEEF, 0));
    add("wr_c2", w1, o_dr(0, 0));
    add("wr_c3", z, o_idle(0));
    add("alt_rst", vi(1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0), o_idle(0));
    add("alt_c0", alt, o_idle(0));
    add("alt_c1", alt, o_mem(32'h80, 4'h0, 0, 0));
    add("alt_c2", alt, o_dr(32'h1234_5678, 0));
    add("alt_c3", alt, o_idle(0));
    add("alt_c4", alt, o_mem(32'h40, 4'h0, 0, 0));
    add("alt_c5", alt, o_ir(32'h1234_5678, 0));
    add("alt_c6", alt, o_idle(0));
    add("alt_c7", alt, o_mem(32'h80, 4'h0, 0, 0));
    add("alt_c8", alt, o_dr(32'h1234_5678, 0));
    add("alt_c9", alt, o_idle(0));
    add("alt_c10", alt, o_mem(32'h40, 4'h0, 0, 0));
    add("alt_c11", alt, o_ir(32'h1234_5678, 0));
    add("alt_c12", z, o_idle(0));
    add("con_c0", cw, o_idle(0));
    add("con_c1", cw, o_con(8'h41, 0));
    add("con_c2", cw, o_con(8'h41, 0));
    add("con_c3", cw, o_con(8'h41, 0));
    add("con_c4", cr4, o_con(8'h41, 0));
    add("con_c5", cw, o_dr(0, 0));
    add("con_c6", z, o_idle(0));
    add("conrd_c0", crd, o_idle(0));
    add("conrd_c1", crd, o_dr(0, 0));
    add("conrd_c2", z, o_idle(0));
    add("rd_c0", rd0, o_idle(0));
    add("rd_c1", rd1, o_mem(32'h200, 4'h0, 0, 0));
    add("rd_c2", rd1, o_mem(32'h200, 4'h0, 0, 0));
    add("rd_c3", rd3, o_mem(32'h200, 4'h0, 0, 0));
    add("rd_c4", rd1, o_ir(32'h0000_0013, 0));
    add("rd_c5", z, o_idle(0));

    repeat (2) @(posedge clk);
    foreach (tbl[k]) begin
      step(tbl[k].name, tbl[k].i, tbl[k].o);
    end

    // Timeout: memory never answers, wait for the abort within a bounded window.
    step("to_c0", vi(0, 1, 32'h300, 0, 0, 4'h0, 0, 0, 0, 0), o_idle(0));
    mv_cnt = 0;
    seen   = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      apply(vi(0, 1, 32'h300, 0, 0, 4'h0, 0, 0, 32'hBAD0_BAD0, 0));
      if (imem_ready) seen = 1'b1;
      else if (mem_valid) mv_cnt++;
    end
    check("to_resp", o_ir(0, 1));
    nvec++;
    if (mv_cnt != 4) begin
      nerr++;
      $display("FAIL to_valid_cycles got=%0d expected=4", mv_cnt);
    end
    step("to_idle", z, o_idle(1));

    // bus_error stays set across a later successful transaction.
    step("sticky_c0", vi(0, 0, 0, 1, 32'h500, 4'h0, 0, 1, 32'h77, 0), o_idle(1));
    step("sticky_c1", vi(0, 0, 0, 1, 32'h500, 4'h0, 0, 1, 32'h77, 0), o_mem(32'h500, 4'h0, 0, 1));
    step("sticky_c2", vi(0, 0, 0, 1, 32'h500, 4'h0, 0, 1, 32'h77, 0), o_dr(32'h77, 1));
    step("sticky_c3", z, o_idle(1));

    // Reset while MEM is waiting: everything returns to zero, no stray ready later.
    step("rstmid_c0", vi(0, 1, 32'h400, 0, 0, 4'h0, 0, 0, 0, 0), o_idle(1));
    step("rstmid_c1", vi(1, 1, 32'h400, 0, 0, 4'h0, 0, 0, 0, 0), o_mem(32'h400, 4'h0, 0, 1));
    step("rstmid_c2", vi(0, 0, 0, 0, 0, 4'h0, 0, 1, 32'h55, 0), o_idle(0));
    step("rstmid_c3", vi(0, 0, 0, 0, 0, 4'h0, 0, 1, 32'h55, 0), o_idle(0));
    step("rstmid_c4", z, o_idle(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
